// File: rtl/cmd_stream_arbiter.sv
// Packet-level two-source AXI-Stream command arbiter with a two-entry output skid buffer.
// Optional stall timeout: define CMD_ARB_STALL_TIMEOUT_EN.
`timescale 1ns / 1ps

module cmd_stream_arbiter #(
  parameter int unsigned CMD_STREAM_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        resetn,
  input  logic                        s0_cmd_axis_tvalid,
  output logic                        s0_cmd_axis_tready,
  input  logic                        s0_cmd_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s0_cmd_axis_tdata,
  input  logic                        s1_cmd_axis_tvalid,
  output logic                        s1_cmd_axis_tready,
  input  logic                        s1_cmd_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s1_cmd_axis_tdata,
  output logic                        m_cmd_axis_tvalid,
  input  logic                        m_cmd_axis_tready,
  output logic                        m_cmd_axis_tlast,
  output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
  output logic [1:0]                  dbgGrant,
  output logic [15:0]                 dbgBeatCount,
  output logic [7:0]                  dbgPktCount0,
  output logic [7:0]                  dbgPktCount1
);

  typedef enum logic [0:0] {StIdle, StTransfer} state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  grant_q, grant_d;
  logic                        last_served_q, last_served_d;

  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [CMD_STREAM_WIDTH-1:0] out_data_q, out_data_d;
  logic                        spare_valid_q, spare_valid_d;
  logic                        spare_last_q, spare_last_d;
  logic [CMD_STREAM_WIDTH-1:0] spare_data_q, spare_data_d;

  logic [15:0]                 beat_cnt_q, beat_cnt_d;
  logic [7:0]                  pkt_cnt0_q, pkt_cnt0_d;
  logic [7:0]                  pkt_cnt1_q, pkt_cnt1_d;

  logic                        src_ready;
  logic                        in_valid;
  logic                        in_last;
  logic [CMD_STREAM_WIDTH-1:0] in_data;
  logic                        real_acc;
  logic                        push;
  logic                        push_last;
  logic [CMD_STREAM_WIDTH-1:0] push_data;
  logic                        pkt_done;
  logic                        drain;

  // Ready depends only on registered state, so no path from m_cmd_axis_tready.
  assign src_ready          = (state_q == StTransfer) && !spare_valid_q;
  assign s0_cmd_axis_tready = src_ready && grant_q[0];
  assign s1_cmd_axis_tready = src_ready && grant_q[1];

  assign in_valid = (grant_q[0] & s0_cmd_axis_tvalid) | (grant_q[1] & s1_cmd_axis_tvalid);
  assign in_last  = grant_q[1] ? s1_cmd_axis_tlast : s0_cmd_axis_tlast;
  assign in_data  = grant_q[1] ? s1_cmd_axis_tdata : s0_cmd_axis_tdata;
  assign real_acc = src_ready && in_valid;

`ifdef CMD_ARB_STALL_TIMEOUT_EN
  logic [11:0] stall_cnt_q, stall_cnt_d;
  logic        stall_fire;

  // Synthetic NOP terminator waits for skid space so no beat is ever dropped.
  assign stall_fire = (state_q == StTransfer) && !in_valid && (stall_cnt_q == 12'hFFF) &&
                      !spare_valid_q;
  assign push       = real_acc || stall_fire;
  assign push_last  = stall_fire || in_last;
  assign push_data  = stall_fire ? '0 : in_data;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != StTransfer) || real_acc || stall_fire) begin
      stall_cnt_d = '0;
    end else if (!in_valid && (stall_cnt_q != 12'hFFF)) begin
      stall_cnt_d = stall_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  assign push      = real_acc;
  assign push_last = in_last;
  assign push_data = in_data;
`endif

  assign pkt_done = push && push_last;
  assign drain    = out_valid_q && m_cmd_axis_tready;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    unique case (state_q)
      StIdle: begin
        if (s0_cmd_axis_tvalid || s1_cmd_axis_tvalid) begin
          state_d = StTransfer;
          // On a tie the source not served last wins.
          if (s0_cmd_axis_tvalid && (!s1_cmd_axis_tvalid || last_served_q)) begin
            grant_d = 2'b01;
          end else begin
            grant_d = 2'b10;
          end
        end
      end
      StTransfer: begin
        if (pkt_done) begin
          state_d       = StIdle;
          grant_d       = 2'b00;
          last_served_d = grant_q[1];
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_data_d    = out_data_q;
    spare_valid_d = spare_valid_q;
    spare_last_d  = spare_last_q;
    spare_data_d  = spare_data_q;
    if (!out_valid_q || drain) begin
      if (spare_valid_q) begin
        out_valid_d   = 1'b1;
        out_last_d    = spare_last_q;
        out_data_d    = spare_data_q;
        spare_valid_d = 1'b0;
      end else if (push) begin
        out_valid_d = 1'b1;
        out_last_d  = push_last;
        out_data_d  = push_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      spare_valid_d = 1'b1;
      spare_last_d  = push_last;
      spare_data_d  = push_data;
    end
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (pkt_done) begin
      beat_cnt_d = '0;
      if (grant_q[0]) pkt_cnt0_d = pkt_cnt0_q + 8'd1;
      if (grant_q[1]) pkt_cnt1_d = pkt_cnt1_q + 8'd1;
    end else if (push && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q       <= StIdle;
      grant_q       <= 2'b00;
      last_served_q <= 1'b1;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      spare_valid_q <= 1'b0;
      spare_last_q  <= 1'b0;
      spare_data_q  <= '0;
      beat_cnt_q    <= '0;
      pkt_cnt0_q    <= '0;
      pkt_cnt1_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
      spare_valid_q <= spare_valid_d;
      spare_last_q  <= spare_last_d;
      spare_data_q  <= spare_data_d;
      beat_cnt_q    <= beat_cnt_d;
      pkt_cnt0_q    <= pkt_cnt0_d;
      pkt_cnt1_q    <= pkt_cnt1_d;
    end
  end

  assign m_cmd_axis_tvalid = out_valid_q;
  assign m_cmd_axis_tlast  = out_last_q;
  assign m_cmd_axis_tdata  = out_data_q;
  assign dbgGrant          = grant_q;
  assign dbgBeatCount      = beat_cnt_q;
  assign dbgPktCount0      = pkt_cnt0_q;
  assign dbgPktCount1      = pkt_cnt1_q;

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Self-checking bench for cmd_stream_arbiter: cycle table for the basic packet flow plus
// source/scoreboard sequences for arbitration, backpressure, stalls and reset.
`timescale 1ns / 1ps

module tb_cmd_stream_arbiter;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        s0_v, s0_ready, s0_l;
  logic [31:0] s0_d;
  logic        s1_v, s1_ready, s1_l;
  logic [31:0] s1_d;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic [1:0]  dbg_grant;
  logic [15:0] dbg_beats;
  logic [7:0]  dbg_pkt0, dbg_pkt1;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  cmd_stream_arbiter #(.CMD_STREAM_WIDTH(32)) dut (
    .aclk               (aclk),
    .resetn             (resetn),
    .s0_cmd_axis_tvalid (s0_v),
    .s0_cmd_axis_tready (s0_ready),
    .s0_cmd_axis_tlast  (s0_l),
    .s0_cmd_axis_tdata  (s0_d),
    .s1_cmd_axis_tvalid (s1_v),
    .s1_cmd_axis_tready (s1_ready),
    .s1_cmd_axis_tlast  (s1_l),
    .s1_cmd_axis_tdata  (s1_d),
    .m_cmd_axis_tvalid  (m_valid),
    .m_cmd_axis_tready  (m_ready),
    .m_cmd_axis_tlast   (m_last),
    .m_cmd_axis_tdata   (m_data),
    .dbgGrant           (dbg_grant),
    .dbgBeatCount       (dbg_beats),
    .dbgPktCount0       (dbg_pkt0),
    .dbgPktCount1       (dbg_pkt1)
  );

  typedef struct {
    logic        s0v;
    logic [31:0] s0d;
    logic        s0l;
    logic        e_rdy;
    logic        e_mv;
    logic [31:0] e_md;
    logic        e_ml;
    logic [1:0]  e_g;
    logic [15:0] e_beats;
    logic [7:0]  e_pkt0;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  vec_t       vecs[11];
  beat_t      src0_q[$], src1_q[$], exp_q[$];
  logic [1:0] grant_log[$];
  int         sent0, sent1, pause_at0, pause_at1, pause_len0, pause_len1, pause_cnt0, pause_cnt1;
  int         mlow_lo, mlow_hi, acc_in_low, idle_cycles, hold_viol;
  logic       s0_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns at a falling edge with resetn released (cycle 0 of the test).
  task automatic do_reset();
    @(negedge aclk);
    resetn = 1'b0;
    s0_v = 0; s0_l = 0; s0_d = '0;
    s1_v = 0; s1_l = 0; s1_d = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    resetn = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " m_tvalid"}, 32'(m_valid), 32'd0);
    chk({tag, " m_tlast"}, 32'(m_last), 32'd0);
    chk({tag, " m_tdata"}, m_data, 32'd0);
    chk({tag, " s0_tready"}, 32'(s0_ready), 32'd0);
    chk({tag, " s1_tready"}, 32'(s1_ready), 32'd0);
    chk({tag, " grant"}, 32'(dbg_grant), 32'd0);
    chk({tag, " beats"}, 32'(dbg_beats), 32'd0);
    chk({tag, " pkt0"}, 32'(dbg_pkt0), 32'd0);
    chk({tag, " pkt1"}, 32'(dbg_pkt1), 32'd0);
  endtask

  task automatic setup();
    src0_q.delete(); src1_q.delete(); exp_q.delete(); grant_log.delete();
    sent0 = 0; sent1 = 0; pause_at0 = -1; pause_at1 = -1;
    pause_len0 = 0; pause_len1 = 0; pause_cnt0 = 0; pause_cnt1 = 0;
    mlow_lo = -1; mlow_hi = -1; acc_in_low = 0; idle_cycles = 0; hold_viol = 0;
  endtask

  task automatic add_pkt(input int src, input logic [31:0] base, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + 32'(i);
      b.l = (i == n - 1);
      if (src == 0) src0_q.push_back(b);
      else src1_q.push_back(b);
    end
  endtask

  // Drives both sources from their queues each cycle and checks every drained output beat
  // against exp_q; acceptances are decided at the falling edge from registered readies.
  task automatic run(input int budget);
    int         cyc;
    logic [1:0] g, prev_g;
    logic       mlow, a0, a1;
    beat_t      b;
    cyc = 0; prev_g = 2'b00; s0_done = 1'b0;
    while (exp_q.size() > 0 && cyc < budget) begin
      s0_v = 1'b0;
      if (src0_q.size() > 0) begin
        if (sent0 == pause_at0 && pause_cnt0 < pause_len0) pause_cnt0++;
        else begin s0_v = 1'b1; s0_d = src0_q[0].d; s0_l = src0_q[0].l; end
      end
      s1_v = 1'b0;
      if (src1_q.size() > 0) begin
        if (sent1 == pause_at1 && pause_cnt1 < pause_len1) pause_cnt1++;
        else begin s1_v = 1'b1; s1_d = src1_q[0].d; s1_l = src1_q[0].l; end
      end
      mlow = (cyc >= mlow_lo) && (cyc < mlow_hi);
      m_ready = !mlow;
      g = dbg_grant;
      if (g != 2'b00 && prev_g == 2'b00) grant_log.push_back(g);
      if (g == 2'b00 && (src0_q.size() + src1_q.size()) > 0) idle_cycles++;
      if (!s0_done && grant_log.size() > 0 && (g != 2'b01 || s1_ready)) hold_viol++;
      prev_g = g;
      a0 = s0_v && s0_ready;
      a1 = s1_v && s1_ready;
      if ((a0 || a1) && mlow) acc_in_low++;
      if (m_valid && m_ready) begin
        b = exp_q.pop_front();
        chk("out_data", m_data, b.d);
        chk("out_last", 32'(m_last), 32'(b.l));
      end
      if (a0) begin
        if (src0_q[0].l) s0_done = 1'b1;
        void'(src0_q.pop_front());
        sent0++;
      end
      if (a1) begin
        void'(src1_q.pop_front());
        sent1++;
      end
      @(negedge aclk);
      cyc++;
    end
    chk("run_beats_left", 32'(exp_q.size()), 32'd0);
    s0_v = 1'b0; s1_v = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    beat_t b;
    // s0: 4-beat packet, then single-beat packets carrying all-zero and all-ones data.
    vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd0, 8'd0};
    vecs[1]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 2'd1, 16'd0, 8'd0};
    vecs[2]  = '{1'b1, 32'h12, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 2'd1, 16'd1, 8'd0};
    vecs[3]  = '{1'b1, 32'h13, 1'b0, 1'b1, 1'b1, 32'h12, 1'b0, 2'd1, 16'd2, 8'd0};
    vecs[4]  = '{1'b1, 32'h14, 1'b1, 1'b1, 1'b1, 32'h13, 1'b0, 2'd1, 16'd3, 8'd0};
    vecs[5]  = '{1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 2'd0, 16'd0, 8'd1};
    vecs[6]  = '{1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2'd1, 16'd0, 8'd1};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 2'd0, 16'd0, 8'd2};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2'd1, 16'd0, 8'd2};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 2'd0, 16'd0, 8'd3};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 16'd0, 8'd3};

    do_reset();
    check_reset("reset");
    for (int i = 0; i < 11; i++) begin
      s0_v = vecs[i].s0v; s0_d = vecs[i].s0d; s0_l = vecs[i].s0l;
      chk($sformatf("t1[%0d] s0_tready", i), 32'(s0_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("t1[%0d] s1_tready", i), 32'(s1_ready), 32'd0);
      chk($sformatf("t1[%0d] m_tvalid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      if (vecs[i].e_mv) begin
        chk($sformatf("t1[%0d] m_tdata", i), m_data, vecs[i].e_md);
        chk($sformatf("t1[%0d] m_tlast", i), 32'(m_last), 32'(vecs[i].e_ml));
      end
      chk($sformatf("t1[%0d] grant", i), 32'(dbg_grant), 32'(vecs[i].e_g));
      chk($sformatf("t1[%0d] beats", i), 32'(dbg_beats), 32'(vecs[i].e_beats));
      chk($sformatf("t1[%0d] pkt0", i), 32'(dbg_pkt0), 32'(vecs[i].e_pkt0));
      @(negedge aclk);
    end

    // Tie at reset release: strict alternation starting with source 0.
    do_reset();
    setup();
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, 32'h100 + 32'(p * 16), 2);
      add_pkt(1, 32'h200 + 32'(p * 16), 2);
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 2; i++) begin b.d = 32'h100 + 32'(p * 16 + i); b.l = (i == 1); exp_q.push_back(b); end
      for (int i = 0; i < 2; i++) begin b.d = 32'h200 + 32'(p * 16 + i); b.l = (i == 1); exp_q.push_back(b); end
    end
    run(200);
    chk("alt grant count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size(); i++) begin
      chk($sformatf("alt grant[%0d]", i), 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    chk("alt idle cycles", 32'(idle_cycles), 32'd6);
    chk("alt pkt0", 32'(dbg_pkt0), 32'd3);
    chk("alt pkt1", 32'(dbg_pkt1), 32'd3);

    // Sink stalls 10 cycles inside a 16-beat packet: only one beat goes to the spare slot.
    do_reset();
    setup();
    add_pkt(0, 32'h300, 16);
    for (int i = 0; i < 16; i++) begin b.d = 32'h300 + 32'(i); b.l = (i == 15); exp_q.push_back(b); end
    mlow_lo = 6; mlow_hi = 16;
    run(200);
    chk("bp beats accepted while stalled", 32'(acc_in_low), 32'd1);
    chk("bp pkt0", 32'(dbg_pkt0), 32'd1);

    // Granted source goes idle 20 cycles mid-packet while source 1 waits.
    do_reset();
    setup();
    add_pkt(0, 32'h400, 6);
    add_pkt(1, 32'h500, 2);
    for (int i = 0; i < 6; i++) begin b.d = 32'h400 + 32'(i); b.l = (i == 5); exp_q.push_back(b); end
    for (int i = 0; i < 2; i++) begin b.d = 32'h500 + 32'(i); b.l = (i == 1); exp_q.push_back(b); end
    pause_at0 = 3; pause_len0 = 20;
    run(200);
    chk("stall hold violations", 32'(hold_viol), 32'd0);
    chk("stall grant count", 32'(grant_log.size()), 32'd2);
    chk("stall pkt0", 32'(dbg_pkt0), 32'd1);
    chk("stall pkt1", 32'(dbg_pkt1), 32'd1);

    // Reset pulse while beat 3 of 8 is presented.
    do_reset();
    s0_v = 1'b1; s0_d = 32'h21; s0_l = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    s0_d = 32'h22;
    @(negedge aclk);
    chk("pre-reset m_tvalid", 32'(m_valid), 32'd1);
    chk("pre-reset m_tdata", m_data, 32'h22);
    chk("pre-reset beats", 32'(dbg_beats), 32'd2);
    s0_d = 32'h23;
    resetn = 1'b0;
    @(negedge aclk);
    resetn = 1'b1;
    s0_v = 1'b0;
    check_reset("midreset");
    setup();
    add_pkt(0, 32'h600, 4);
    for (int i = 0; i < 4; i++) begin b.d = 32'h600 + 32'(i); b.l = (i == 3); exp_q.push_back(b); end
    run(100);
    chk("post-reset pkt0", 32'(dbg_pkt0), 32'd1);

`ifdef CMD_ARB_STALL_TIMEOUT_EN
    // Source 0 stalls forever after one beat: a zero tlast beat closes its packet.
    do_reset();
    setup();
    add_pkt(0, 32'h700, 2);
    add_pkt(1, 32'h800, 2);
    pause_at0 = 1; pause_len0 = 100000;
    b.d = 32'h700; b.l = 1'b0; exp_q.push_back(b);
    b.d = 32'h0;   b.l = 1'b1; exp_q.push_back(b);
    b.d = 32'h800; b.l = 1'b0; exp_q.push_back(b);
    b.d = 32'h801; b.l = 1'b1; exp_q.push_back(b);
    run(5000);
    chk("timeout pkt0", 32'(dbg_pkt0), 32'd1);
    chk("timeout pkt1", 32'(dbg_pkt1), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
